serial_subtractor_16bit: RTL and testbench
==========================================

# serial_subtractor_16bit

Multi-cycle 16-bit two's-complement subtractor computing `d = a - b - bin`. It consumes operands a configurable number of bits (a digit) per clock, LSB digit first, and uses a start/busy/done handshake. It is the inverse companion of the 16-bit ripple-carry adder in the arithmetic datapath. A full-width ripple borrow chain is avoided by iterating one narrow digit slice.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width in bits.
- `DIGIT`, 1, bits processed per cycle. Must divide `WIDTH` exactly (legal: 1, 2, 4, 8, 16).

Ports:
- `clk`  input  1  sole clock, rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request. Sampled on `clk` rising edge; accepted only when `busy`=0.
- `a`  input  WIDTH  minuend. Latched on an accepted start.
- `b`  input  WIDTH  subtrahend. Latched on an accepted start.
- `bin`  input  1  borrow in. Latched on an accepted start.
- `d`  output  WIDTH  difference. Registered.
- `bout`  output  1  borrow out: 1 when `a < b + bin` (unsigned).
- `overflow`  output  1  signed overflow of `a - b - bin`.
- `busy`  output  1  high while the block is in RUN.
- `done`  output  1  one-cycle pulse when `d`/`bout`/`overflow` become valid.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 at an edge: latch `a`, `b`, `bin`; clear digit counter; go to RUN.
  - Otherwise stay in IDLE.
- RUN: each edge processes digit k (bits `k*DIGIT .. k*DIGIT+DIGIT-1`).
  - Computes `a_k + ~b_k + (~borrow)` as a DIGIT-bit add.
  - Writes the digit of the internal result shift register.
  - Updates the borrow register. The borrow register is initialised to `bin`.
  - After digit `WIDTH/DIGIT-1`: go to DONE.
- DONE:
  - Transfer the result to `d`; `bout` = final borrow.
  - `overflow` = (`a[MSB]` != `b[MSB]`) && (`d[MSB]` != `a[MSB]`), using latched operands.
  - Assert `done` for exactly this cycle.
  - Next edge: go to RUN if `start`=1 (new operands latched), else IDLE.
- `start` while `busy`=1: ignored. No queuing, no effect on the operation in flight.
- `d`, `bout`, `overflow` hold their last valid values until the next DONE. They do not change during RUN.
- Operand inputs may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH. `bout`=1 exactly when the unsigned true result is negative.

## Timing
- Reset (asynchronous, takes effect immediately, any state):
  - State → IDLE.
  - `d`=0, `bout`=0, `overflow`=0, `busy`=0, `done`=0.
  - Counter, borrow, and operand registers cleared.
- Reset mid-RUN aborts the operation. No `done` pulse. Outputs read 0.
- Latency: start accepted at edge E0.
  - `busy`=1 from E0 through edge E0+WIDTH/DIGIT.
  - `done`=1 and results valid in the cycle following edge E0+WIDTH/DIGIT.
  - Default configuration: 16 cycles start-to-done.
  - DIGIT=16: 1 cycle.
- `busy`=0 in DONE, so back-to-back starts are allowed. Throughput is one result per WIDTH/DIGIT+1 cycles.
- `done` and `busy` are never high together.

## Configuration
- `SUB_OVERFLOW_EN` defined: overflow detection logic is compiled in, and `overflow` behaves as specified above.
- `SUB_OVERFLOW_EN` undefined:
  - Overflow logic and the operand-MSB storage it needs are removed.
  - `overflow` is tied to constant 0.
  - `d`, `bout`, and timing are unchanged.

## Test plan
- a=65500, b=35, bin=0 → after 16 cycles: d=65465, bout=0, overflow=0, single-cycle `done`.
- a=35, b=65500, bin=0 → d=71, bout=1, overflow=0. Then a=6000, b=35, bin=1 started in the DONE cycle → d=5964, bout=0, with no idle gap.
- a=0, b=0, bin=1 → d=65535, bout=1. Also a=16'h8000, b=1, bin=0 → d=16'h7FFF, overflow=1 with `SUB_OVERFLOW_EN` defined, and overflow=0 without it.
- Start a=100, b=1; pulse `start` with a=5, b=5 at cycle 5 → ignored. Result d=99; exactly one `done`.
- Start an operation; assert `rst` asynchronously at cycle 8 → all outputs 0 immediately, no `done`. After release, a new start completes normally.
- Repeat the first scenario with DIGIT=4 and DIGIT=16 → identical results, latency 4 and 1 cycles respectively.

Source files
------------

// File: rtl/serial_subtractor_16bit.sv
// Digit-serial two's-complement subtractor: d = a - b - bin, DIGIT bits per clock, LSB digit first.
// Define SUB_OVERFLOW_EN to compile in signed-overflow detection; otherwise overflow is tied to 0.
module serial_subtractor_16bit #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic [IW-1:0]    base;
   logic [DIGIT:0]   sum;
`ifdef SUB_OVERFLOW_EN
   logic             ovf_q, ovf_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      d_d      = d_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
`ifdef SUB_OVERFLOW_EN
      ovf_d    = ovf_q;
`endif
      base = IW'(int'(cnt_q) * DIGIT);
      // Subtraction as a + ~b + ~borrow; the digit carry-out is the inverted borrow-out.
      sum  = {1'b0, a_q[base +: DIGIT]} + {1'b0, ~b_q[base +: DIGIT]} + {{DIGIT{1'b0}}, ~borrow_q};

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               borrow_d = bin;
               cnt_d    = '0;
               state_d  = S_RUN;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_RUN: begin
            res_d[base +: DIGIT] = sum[DIGIT-1:0];
            borrow_d = ~sum[DIGIT];
            cnt_d    = cnt_q + CW'(1);
            // Results are loaded on the last digit edge so they are valid in the DONE cycle.
            if (cnt_q == LAST_DIG) begin
               state_d = S_DONE;
               d_d     = res_d;
               bout_d  = ~sum[DIGIT];
`ifdef SUB_OVERFLOW_EN
               ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         d_q      <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         d_q      <= d_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
`ifdef SUB_OVERFLOW_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign d    = d_q;
   assign bout = bout_q;
   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
`ifdef SUB_OVERFLOW_EN
   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Bench for serial_subtractor_16bit: directed table, hand-written handshake/reset sequences,
// and random operands on DIGIT=1/4/16 instances checked against an arithmetic model.
module tb_serial_subtractor_16bit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start1, start4, start16;
   logic [15:0] a_i, b_i;
   logic        bin_i;

   logic [15:0] d1, d4, d16;
   logic        bout1, bout4, bout16;
   logic        ovf1, ovf4, ovf16;
   logic        busy1, busy4, busy16;
   logic        done1, done4, done16;

   serial_subtractor_16bit #(.WIDTH(16), .DIGIT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a_i), .b(b_i), .bin(bin_i),
      .d(d1), .bout(bout1), .overflow(ovf1), .busy(busy1), .done(done1));
   serial_subtractor_16bit #(.WIDTH(16), .DIGIT(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a_i), .b(b_i), .bin(bin_i),
      .d(d4), .bout(bout4), .overflow(ovf4), .busy(busy4), .done(done4));
   serial_subtractor_16bit #(.WIDTH(16), .DIGIT(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a_i), .b(b_i), .bin(bin_i),
      .d(d16), .bout(bout16), .overflow(ovf16), .busy(busy16), .done(done16));

   typedef struct packed {
      logic [15:0] d;
      logic        bout;
      logic        ovf;
      logic        busy;
      logic        done;
   } obs_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [15:0] ed;
      logic        eb;
      logic        eo;
   } vec_t;

`ifdef SUB_OVERFLOW_EN
   localparam logic OV_ON = 1'b1;
`else
   localparam logic OV_ON = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic obs_t observe(input int w);
      case (w)
         1:       return {d1, bout1, ovf1, busy1, done1};
         4:       return {d4, bout4, ovf4, busy4, done4};
         default: return {d16, bout16, ovf16, busy16, done16};
      endcase
   endfunction

   // Reference: plain integer arithmetic on the operand values.
   task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        output logic [15:0] ed, output logic eb, output logic eo);
      int ua, ub, sa, sb, sr;
      ua = a;  ub = b;
      sa = $signed(a);  sb = $signed(b);
      sr = sa - sb - int'(bin);
      ed = 16'((ua - ub - int'(bin)) & 32'hFFFF);
      eb = (ua < ub + int'(bin));
      eo = OV_ON & ((sr > 32767) || (sr < -32768));
   endtask

   task automatic start_now(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin);
      a_i = a;  b_i = b;  bin_i = bin;
      case (w)
         1:       start1 = 1'b1;
         4:       start4 = 1'b1;
         default: start16 = 1'b1;
      endcase
      @(posedge clk); #1;
      start1 = 1'b0;  start4 = 1'b0;  start16 = 1'b0;
   endtask

   task automatic start_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin);
      @(negedge clk);
      start_now(w, a, b, bin);
   endtask

   // Called just after the accepting edge; returns sampled in the done cycle.
   task automatic wait_done(input int w, input string tag, input logic [15:0] hold,
                            input int elat, output obs_t o);
      int lat;
      logic ok, held, excl;
      lat = 0;  ok = 1'b0;  held = 1'b1;  excl = 1'b1;
      o = observe(w);
      chk({tag, " busy_after_start"}, 32'(o.busy), 32'd1);
      while (!ok && lat < 64) begin
         @(posedge clk); #1;
         lat++;
         o = observe(w);
         if (o.busy && o.done) excl = 1'b0;
         if (o.done) ok = 1'b1;
         else if (o.d !== hold) held = 1'b0;
      end
      chk({tag, " done_seen"}, 32'(ok), 32'd1);
      chk({tag, " latency"}, 32'(lat), 32'(elat));
      chk({tag, " d_held_in_run"}, 32'(held), 32'd1);
      chk({tag, " busy_done_excl"}, 32'(excl), 32'd1);
   endtask

   task automatic run_check(input int w, input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic bin, input logic [15:0] ed, input logic eb, input logic eo,
                            input int elat);
      obs_t o;
      logic [15:0] hold;
      hold = observe(w).d;
      start_op(w, a, b, bin);
      wait_done(w, tag, hold, elat, o);
      chk({tag, " d"}, 32'(o.d), 32'(ed));
      chk({tag, " bout"}, 32'(o.bout), 32'(eb));
      chk({tag, " overflow"}, 32'(o.ovf), 32'(eo));
      @(posedge clk); #1;
      o = observe(w);
      chk({tag, " done_one_cycle"}, 32'(o.done), 32'd0);
      chk({tag, " d_held_after"}, 32'(o.d), 32'(ed));
   endtask

   vec_t tbl[6];

   initial begin
      obs_t o;
      logic [15:0] hold, ed, ra, rb;
      logic eb, eo, rbin;
      int dones, lat_seen;

      tbl[0] = '{16'd65500, 16'd35,    1'b0, 16'd65465, 1'b0, 1'b0};
      tbl[1] = '{16'd35,    16'd65500, 1'b0, 16'd71,    1'b1, 1'b0};
      tbl[2] = '{16'd6000,  16'd35,    1'b1, 16'd5964,  1'b0, 1'b0};
      tbl[3] = '{16'd0,     16'd0,     1'b1, 16'd65535, 1'b1, 1'b0};
      tbl[4] = '{16'h8000,  16'd1,     1'b0, 16'h7FFF,  1'b0, OV_ON};
      tbl[5] = '{16'd100,   16'd1,     1'b0, 16'd99,    1'b0, 1'b0};

      rst = 1'b1;  start1 = 1'b0;  start4 = 1'b0;  start16 = 1'b0;
      a_i = '0;  b_i = '0;  bin_i = 1'b0;
      #12;
      o = observe(1);
      chk("reset dut1 outputs", 32'(o), 32'd0);
      o = observe(4);
      chk("reset dut4 outputs", 32'(o), 32'd0);
      o = observe(16);
      chk("reset dut16 outputs", 32'(o), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++)
         run_check(1, $sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin,
                   tbl[i].ed, tbl[i].eb, tbl[i].eo, 16);

      run_check(4,  "digit4",  tbl[0].a, tbl[0].b, tbl[0].bin, tbl[0].ed, tbl[0].eb, tbl[0].eo, 4);
      run_check(16, "digit16", tbl[0].a, tbl[0].b, tbl[0].bin, tbl[0].ed, tbl[0].eb, tbl[0].eo, 1);

      // Back-to-back: second start issued in the DONE cycle of the first.
      hold = observe(1).d;
      start_op(1, 16'd35, 16'd65500, 1'b0);
      wait_done(1, "b2b_first", hold, 16, o);
      chk("b2b_first d", 32'(o.d), 32'd71);
      chk("b2b_first bout", 32'(o.bout), 32'd1);
      start_now(1, 16'd6000, 16'd35, 1'b1);
      wait_done(1, "b2b_second", 16'd71, 16, o);
      chk("b2b_second d", 32'(o.d), 32'd5964);
      chk("b2b_second bout", 32'(o.bout), 32'd0);

      // Start pulse while busy is ignored.
      @(posedge clk); #1;
      start_op(1, 16'd100, 16'd1, 1'b0);
      dones = 0;  lat_seen = 0;  hold = 16'hDEAD;
      for (int c = 1; c <= 30; c++) begin
         if (c == 5) begin
            a_i = 16'd5;  b_i = 16'd5;  start1 = 1'b1;
         end
         @(posedge clk); #1;
         start1 = 1'b0;
         if (done1) begin
            dones++;
            lat_seen = c;
            hold = d1;
         end
      end
      chk("ignored_start done_count", 32'(dones), 32'd1);
      chk("ignored_start latency", 32'(lat_seen), 32'd16);
      chk("ignored_start d", 32'(hold), 32'd99);

      // Asynchronous reset mid-operation.
      start_op(1, 16'd65500, 16'd35, 1'b0);
      repeat (7) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      o = observe(1);
      chk("async_rst outputs", 32'(o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done1) dones++;
      end
      chk("async_rst no_done", 32'(dones), 32'd0);
      run_check(1, "after_rst", 16'd6000, 16'd35, 1'b1, 16'd5964, 1'b0, 1'b0, 16);

      for (int i = 0; i < 25; i++) begin
         ra = 16'($urandom);  rb = 16'($urandom);  rbin = 1'($urandom);
         if (i == 0) begin ra = 16'h7FFF; rb = 16'hFFFF; rbin = 1'b0; end
         if (i == 1) begin ra = 16'h8000; rb = 16'h0000; rbin = 1'b1; end
         model(ra, rb, rbin, ed, eb, eo);
         run_check(1,  $sformatf("rnd1_%0d", i),  ra, rb, rbin, ed, eb, eo, 16);
         run_check(4,  $sformatf("rnd4_%0d", i),  ra, rb, rbin, ed, eb, eo, 4);
         run_check(16, $sformatf("rnd16_%0d", i), ra, rb, rbin, ed, eb, eo, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
